seq_alu: RTL and testbench

- Registered, handshaked successor to the combinational N-bit ALU.
- Adds AND, logical shifts and an iterative multi-cycle multiply, plus Z/C/N/V status flags.
- Uses valid/ready on both input and output sides. Sits between an operand-issue stage and a result-writeback stage.
- Holds one operation in flight at a time. Back-to-back issue is possible when the result drains in the same cycle.

---
 rtl/seq_alu.sv | 161 ++++++++++++++++
 tb/tb_seq_alu.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered, valid/ready handshaked ALU with Z/C/N/V flags and an
// iterative shift-add multiplier. One operation in flight at a time.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation held; ready to accept
// BUSY  | multiply in progress, one multiplier bit per cycle
// DONE  | result valid on out/flags; held until the consumer takes it
module seq_alu #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in0,
  input  logic [2:0]   opcode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_n,
  output logic         flag_v
);

  localparam int CW = $clog2(N + 1);
  localparam logic [N:0] N_EXT = (N + 1)'(N);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic           accept;
  logic           mul_last;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_nxt;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;

  logic [N:0]     sum;
  logic [N:0]     diff;
  logic           shift_oor;
  logic [N-1:0]   alu_res;
  logic           alu_c;
  logic           alu_v;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign mul_last  = (cnt == CW'(1));
  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);

  // Single-cycle ops evaluated straight from the input operands at accept.
  always_comb begin
    sum       = {1'b0, in1} + {1'b0, in0};
    diff      = {1'b0, in1} - {1'b0, in0};
    shift_oor = ({1'b0, in0} >= N_EXT);
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = (in1[N-1] == in0[N-1]) && (sum[N-1] != in1[N-1]);
      end
      OP_OR:  alu_res = in1 | in0;
      OP_SUB: begin
        alu_res = diff[N-1:0];
        alu_c   = diff[N];
        alu_v   = (in1[N-1] != in0[N-1]) && (diff[N-1] != in1[N-1]);
      end
      OP_XOR: alu_res = in1 ^ in0;
      OP_AND: alu_res = in1 & in0;
      OP_SHL: alu_res = shift_oor ? '0 : (in1 << in0);
      OP_SHR: alu_res = shift_oor ? '0 : (in1 >> in0);
      default: alu_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: an accept from DONE behaves exactly like an accept from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (opcode == OP_MUL) ? BUSY : DONE;
      end
      BUSY: begin
        if (mul_last) state_nxt = DONE;
      end
      DONE: begin
        if (accept)         state_nxt = (opcode == OP_MUL) ? BUSY : DONE;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture at accept, step the multiplier in BUSY, register results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      out    <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else if (accept) begin
      if (opcode == OP_MUL) begin
        mcand  <= {{N{1'b0}}, in1};
        mplier <= in0;
        acc    <= '0;
        cnt    <= CW'(N);
      end else begin
        out    <= alu_res;
        flag_z <= (alu_res == '0);
        flag_c <= alu_c;
        flag_n <= alu_res[N-1];
        flag_v <= alu_v;
      end
    end else if (state == BUSY) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (mul_last) begin
        out    <= acc_nxt[N-1:0];
        flag_z <= (acc_nxt[N-1:0] == '0);
        flag_c <= (acc_nxt[2*N-1:N] != '0);
        flag_n <= acc_nxt[N-1];
        flag_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu (N=8): table-driven vectors checked through a
// scoreboard queue, plus hand-written latency, backpressure and reset cases.
module tb_seq_alu;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in1;
  logic [N-1:0] in0;
  logic [2:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic         flag_z, flag_c, flag_n, flag_v;

  seq_alu #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in0       (in0),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_n    (flag_n),
    .flag_v    (flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eo;
    logic [3:0] ef;   // {Z,C,N,V}
  } vec_t;

  typedef struct packed {
    logic [7:0] o;
    logic [3:0] f;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: compare each result on the cycle it is handed over.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_out", {24'd0, out}, {24'd0, e.o});
        check("sb_flags", {28'd0, flag_z, flag_c, flag_n, flag_v}, {28'd0, e.f});
      end
    end
  end

  // Present an operation, wait for acceptance, optionally expect its result.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eo, input logic [3:0] ef, input bit push);
    int t;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in1      = a;
    in0      = b;
    opcode   = op;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    if (push) begin
      e.o = eo;
      e.f = ef;
      exp_q.push_back(e);
    end
    #1;
    in_valid = 1'b0;
    in1      = 8'($urandom);
    in0      = 8'($urandom);
    opcode   = 3'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 4'b1100};
    vecs[1]  = '{3'd2, 8'h80, 8'h01, 8'h7F, 4'b0001};
    vecs[2]  = '{3'd2, 8'h03, 8'h05, 8'hFE, 4'b0110};
    vecs[3]  = '{3'd5, 8'h81, 8'h01, 8'h02, 4'b0000};
    vecs[4]  = '{3'd6, 8'h81, 8'h07, 8'h01, 4'b0000};
    vecs[5]  = '{3'd5, 8'hFF, 8'h08, 8'h00, 4'b1000};
    vecs[6]  = '{3'd7, 8'h10, 8'h11, 8'h10, 4'b0100};
    vecs[7]  = '{3'd7, 8'h0F, 8'h0F, 8'hE1, 4'b0010};
    vecs[8]  = '{3'd1, 8'h0F, 8'hF0, 8'hFF, 4'b0010};
    vecs[9]  = '{3'd4, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[10] = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b0011};
    vecs[11] = '{3'd6, 8'h80, 8'h09, 8'h00, 4'b1000};
    vecs[12] = '{3'd3, 8'h5A, 8'h5A, 8'h00, 4'b1000};
    vecs[13] = '{3'd7, 8'hFF, 8'hFF, 8'h01, 4'b0100};
    vecs[14] = '{3'd2, 8'h05, 8'h05, 8'h00, 4'b1000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in1       = '0;
    in0       = '0;
    opcode    = '0;
    out_ready = 1'b1;

    // Reset state.
    #23;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out", {24'd0, out}, 32'd0);
    check("rst_flags", {28'd0, flag_z, flag_c, flag_n, flag_v}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD latency: result valid the cycle after accept.
    issue(3'd0, 8'hFF, 8'h01, 8'h00, 4'b1100, 1'b1);
    check("add_latency_valid", {31'd0, out_valid}, 32'd1);
    check("add_latency_out", {24'd0, out}, 32'd0);
    drain();

    // Vector table, issued back to back.
    for (int i = 0; i < 15; i++)
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eo, vecs[i].ef, 1'b1);
    drain();

    // MUL timing: out_valid rises exactly N edges after accept.
    issue(3'd7, 8'h10, 8'h11, 8'h10, 4'b0100, 1'b1);
    check("mul_e0_valid", {31'd0, out_valid}, 32'd0);
    check("mul_e0_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 1; i <= N; i++) begin
      @(posedge clk);
      #1;
      if (i < N) begin
        check("mul_busy_valid", {31'd0, out_valid}, 32'd0);
        check("mul_busy_ready", {31'd0, in_ready}, 32'd0);
      end else begin
        check("mul_done_valid", {31'd0, out_valid}, 32'd1);
      end
    end
    drain();

    // Backpressure, then drain-and-accept in the same cycle.
    @(negedge clk);
    out_ready = 1'b0;
    issue(3'd0, 8'h12, 8'h34, 8'h46, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out", {24'd0, out}, 32'h46);
      check("bp_flags", {28'd0, flag_z, flag_c, flag_n, flag_v}, 32'd0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    issue(3'd3, 8'hAA, 8'hFF, 8'h55, 4'b0000, 1'b1);
    check("b2b_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_out", {24'd0, out}, 32'h55);
    drain();

    // Leave non-zero out/flags, then reset in the 4th BUSY cycle of a MUL.
    issue(3'd2, 8'h03, 8'h05, 8'hFE, 4'b0110, 1'b1);
    drain();
    issue(3'd7, 8'h10, 8'h11, 8'h00, 4'b0000, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out", {24'd0, out}, 32'd0);
    check("abort_flags", {28'd0, flag_z, flag_c, flag_n, flag_v}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    issue(3'd0, 8'h02, 8'h03, 8'h05, 4'b0000, 1'b1);
    check("post_rst_out", {24'd0, out}, 32'h05);
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
